dmem_arbiter: RTL and testbench

//  Shares the single-port 256x16 data RAM between the CPU datapath (D_Addr/D_Wr side) and a DMA loader.

---
 rtl/dmem_arb_pkg.sv | 22 ++
 rtl/dmem_arb_rd_pipe.sv | 50 +++++
 rtl/dmem_arbiter.sv | 179 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the data-RAM arbiter.
package dmem_arb_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_LEN_W  = 4;
  localparam int DEF_RD_LAT = 1;

  // Encoding doubles as the debug owner output (00 IDLE, 01 CPU, 10 DMA).
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CPU  = 2'b01,
    ST_DMA  = 2'b10
  } state_e;

  // Which master a pending read belongs to.
  typedef enum logic {
    TAG_CPU = 1'b0,
    TAG_DMA = 1'b1
  } tag_e;

endpackage

// File: rtl/dmem_arb_rd_pipe.sv
// Read-return tag pipeline: delays {valid, owner tag} by RD_LAT cycles so the
// RAM read data can be steered to the master that issued the read.
module dmem_arb_rd_pipe
  import dmem_arb_pkg::*;
#(
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic clk,
  input  logic srst,
  input  logic in_valid,
  input  tag_e in_tag,
  output logic out_valid,
  output tag_e out_tag
);

  logic valid_reg [RD_LAT];
  tag_e tag_reg   [RD_LAT];

  generate
    for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        // First stage captures the read issued this cycle.
        always_ff @(posedge clk) begin
          if (srst) begin
            valid_reg[gi] <= 1'b0;
            tag_reg[gi]   <= TAG_CPU;
          end else begin
            valid_reg[gi] <= in_valid;
            tag_reg[gi]   <= in_tag;
          end
        end
      end else begin : g_body
        // Later stages shift the tag along one cycle each.
        always_ff @(posedge clk) begin
          if (srst) begin
            valid_reg[gi] <= 1'b0;
            tag_reg[gi]   <= TAG_CPU;
          end else begin
            valid_reg[gi] <= valid_reg[gi-1];
            tag_reg[gi]   <= tag_reg[gi-1];
          end
        end
      end
    end
  endgenerate

  assign out_valid = valid_reg[RD_LAT-1];
  assign out_tag   = tag_reg[RD_LAT-1];

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter sharing the single-port data RAM between the CPU (single beats)
// and a DMA loader (incrementing bursts). One RAM access per clock; the
// grant and RAM controls are decoded from the registered state.
// Build option: DMEM_ARB_RR_EN selects round-robin priority; without it the
// CPU has fixed priority.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W,
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_wr,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [LEN_W-1:0]  dma_len,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        owner
);

`ifdef DMEM_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  state_e              state_reg, state_next;
  logic                prio_cpu_reg, prio_cpu_next;
  logic [ADDR_W-1:0]   base_reg, base_next;
  logic [LEN_W-1:0]    len_reg, len_next;
  logic [LEN_W-1:0]    beat_reg, beat_next;
  logic                wr_reg, wr_next;
  logic                arb;
  logic                prio_eff;
  logic                rd_issue;
  tag_e                rd_tag;
  logic                pipe_valid;
  tag_e                pipe_tag;

  // Next-state logic: arbitrate in IDLE, after a CPU beat, and on the last
  // DMA beat; otherwise advance or abort the running burst.
  always_comb begin
    state_next    = state_reg;
    base_next     = base_reg;
    len_next      = len_reg;
    beat_next     = beat_reg;
    wr_next       = wr_reg;
    arb           = 1'b0;
    prio_eff      = prio_cpu_reg;

    case (state_reg)
      ST_IDLE: arb = 1'b1;
      ST_CPU: begin
        arb = 1'b1;
        // A finished CPU beat hands priority to DMA in round-robin mode.
        if (RR_EN) prio_eff = 1'b0;
      end
      ST_DMA: begin
        if (!dma_req) begin
          // Burst abandoned by the loader: no access, back to idle.
          state_next = ST_IDLE;
        end else if (beat_reg == len_reg) begin
          arb = 1'b1;
          // A finished burst hands priority back to the CPU.
          if (RR_EN) prio_eff = 1'b1;
        end else begin
          beat_next = beat_reg + LEN_W'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase

    prio_cpu_next = prio_eff;

    if (arb) begin
      if (cpu_req && (prio_eff || !dma_req)) begin
        state_next = ST_CPU;
      end else if (dma_req) begin
        state_next = ST_DMA;
        base_next  = dma_addr;
        len_next   = dma_len;
        wr_next    = dma_wr;
        beat_next  = '0;
      end else begin
        state_next = ST_IDLE;
      end
    end
  end

  // State, priority and burst-context registers.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_reg    <= ST_IDLE;
      prio_cpu_reg <= 1'b1;
      base_reg     <= '0;
      len_reg      <= '0;
      beat_reg     <= '0;
      wr_reg       <= 1'b0;
    end else begin
      state_reg    <= state_next;
      prio_cpu_reg <= prio_cpu_next;
      base_reg     <= base_next;
      len_reg      <= len_next;
      beat_reg     <= beat_next;
      wr_reg       <= wr_next;
    end
  end

  // Grant and RAM-port decode from the current state.
  always_comb begin
    cpu_gnt   = 1'b0;
    dma_gnt   = 1'b0;
    dma_done  = 1'b0;
    mem_addr  = '0;
    mem_wr    = 1'b0;
    mem_wdata = '0;
    rd_issue  = 1'b0;
    rd_tag    = TAG_CPU;

    case (state_reg)
      ST_CPU: begin
        cpu_gnt   = 1'b1;
        mem_addr  = cpu_addr;
        mem_wr    = cpu_wr;
        mem_wdata = cpu_wdata;
        rd_issue  = !cpu_wr;
        rd_tag    = TAG_CPU;
      end
      ST_DMA: begin
        if (dma_req) begin
          dma_gnt   = 1'b1;
          mem_addr  = base_reg + ADDR_W'(beat_reg);
          mem_wr    = wr_reg;
          mem_wdata = dma_wdata;
          dma_done  = (beat_reg == len_reg);
          rd_issue  = !wr_reg;
          rd_tag    = TAG_DMA;
        end
      end
      default: ;
    endcase
  end

  dmem_arb_rd_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk       (Clk),
    .srst      (Rst),
    .in_valid  (rd_issue),
    .in_tag    (rd_tag),
    .out_valid (pipe_valid),
    .out_tag   (pipe_tag)
  );

  assign cpu_rvalid = pipe_valid && (pipe_tag == TAG_CPU);
  assign dma_rvalid = pipe_valid && (pipe_tag == TAG_DMA);
  assign cpu_rdata  = mem_rdata;
  assign dma_rdata  = mem_rdata;
  assign owner      = state_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a behavioural 256x16 RAM
// (one-cycle read latency). Expected read data is queued when a read is
// issued and compared when the matching rvalid appears.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        cpu_req = 1'b0, cpu_wr = 1'b0;
  logic [7:0]  cpu_addr = '0;
  logic [15:0] cpu_wdata = '0;
  logic        cpu_gnt, cpu_rvalid;
  logic [15:0] cpu_rdata;
  logic        dma_req = 1'b0, dma_wr = 1'b0;
  logic [7:0]  dma_addr = '0;
  logic [3:0]  dma_len = '0;
  logic [15:0] dma_wdata = '0;
  logic        dma_gnt, dma_rvalid, dma_done;
  logic [15:0] dma_rdata;
  logic [7:0]  mem_addr;
  logic        mem_wr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic [1:0]  owner;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] ram   [256];
  logic [15:0] model [256];
  logic [15:0] cpu_q [$];
  logic [15:0] dma_q [$];

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
  } cpu_vec_t;

  cpu_vec_t vecs [10];

  always #5 Clk = ~Clk;

  dmem_arbiter #(.ADDR_W(8), .DATA_W(16), .LEN_W(4), .RD_LAT(1)) dut (
    .Clk(Clk), .Rst(Rst),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_len(dma_len),
    .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid),
    .dma_rdata(dma_rdata), .dma_done(dma_done),
    .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .owner(owner)
  );

  // Behavioural RAM, one-cycle registered read.
  always @(posedge Clk) begin
    if (mem_wr) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every rvalid must match the oldest queued expectation.
  always @(negedge Clk) begin
    if (cpu_rvalid) begin
      if (cpu_q.size() == 0) chk("cpu_stray_rvalid", 32'(cpu_rvalid), 32'd0);
      else                   chk("cpu_rdata", 32'(cpu_rdata), 32'(cpu_q.pop_front()));
    end
    if (dma_rvalid) begin
      if (dma_q.size() == 0) chk("dma_stray_rvalid", 32'(dma_rvalid), 32'd0);
      else                   chk("dma_rdata", 32'(dma_rdata), 32'(dma_q.pop_front()));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [15:0] wd(input logic [7:0] a);
    return {a, ~a};
  endfunction

  // Single CPU access from IDLE; entered and left at posedge+1.
  task automatic cpu_op(input logic wr, input logic [7:0] addr,
                        input logic [15:0] wdata, input logic [15:0] exp_rd);
    int lat;
    cpu_req = 1'b1; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wdata;
    if (wr) model[addr] = wdata;
    else    cpu_q.push_back(exp_rd);
    @(negedge Clk);
    chk("cpu_gnt_early", 32'(cpu_gnt), 32'd0);
    tick();
    lat = 1;
    while (!cpu_gnt && lat < 20) begin tick(); lat++; end
    chk("cpu_gnt_latency", 32'(lat), 32'd1);
    cpu_req = 1'b0;
    @(negedge Clk);
    chk("cpu_mem_addr", 32'(mem_addr), 32'(addr));
    chk("cpu_mem_wr", 32'(mem_wr), 32'(wr));
    if (wr) chk("cpu_mem_wdata", 32'(mem_wdata), 32'(wdata));
    tick();
    @(negedge Clk);
    chk("cpu_single_grant", 32'(cpu_gnt), 32'd0);
    if (!wr) chk("cpu_rvalid_timing", 32'(cpu_rvalid), 32'd1);
    $display("cpu %s addr=%02h data=%04h latency=%0d", wr ? "wr" : "rd", addr, wr ? wdata : exp_rd, lat);
    tick();
  endtask

  // DMA burst from IDLE. abort_at / rst_at / cpu_at = beat index or -1.
  task automatic dma_burst(input logic wr, input logic [7:0] base, input logic [3:0] len,
                           input int abort_at, input int rst_at, input int cpu_at);
    int lat;
    logic [7:0] a;
    logic ended;
    ended = 1'b0;
    dma_req = 1'b1; dma_wr = wr; dma_addr = base; dma_len = len; dma_wdata = wd(base);
    @(negedge Clk);
    chk("dma_gnt_early", 32'(dma_gnt), 32'd0);
    tick();
    lat = 1;
    while (!dma_gnt && lat < 20) begin tick(); lat++; end
    chk("dma_gnt_latency", 32'(lat), 32'd1);
    for (int i = 0; i <= int'(len); i++) begin
      a = base + 8'(i);
      if (i == cpu_at) begin
        cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 8'h12; cpu_wdata = 16'h7777;
        model[8'h12] = 16'h7777;
      end
      if (i == abort_at) begin
        dma_req = 1'b0;
        @(negedge Clk);
        chk("abort_gnt", 32'(dma_gnt), 32'd0);
        chk("abort_mem_wr", 32'(mem_wr), 32'd0);
        chk("abort_done", 32'(dma_done), 32'd0);
        tick();
        @(negedge Clk);
        chk("abort_owner", 32'(owner), 32'd0);
        tick();
        ended = 1'b1;
        break;
      end
      if (i == rst_at) Rst = 1'b1;           // this beat still happens; its read is flushed
      else if (wr)     model[a] = wd(a);
      else             dma_q.push_back(model[a]);
      dma_wdata = wd(a);
      @(negedge Clk);
      chk("dma_gnt", 32'(dma_gnt), 32'd1);
      chk("dma_mem_addr", 32'(mem_addr), 32'(a));
      chk("dma_mem_wr", 32'(mem_wr), 32'(wr));
      chk("dma_done", 32'(dma_done), 32'(i == int'(len)));
      if (wr) chk("dma_mem_wdata", 32'(mem_wdata), 32'(wd(a)));
      if (cpu_at >= 0 && i >= cpu_at) chk("cpu_blocked", 32'(cpu_gnt), 32'd0);
      if (i == rst_at) begin
        tick();
        @(negedge Clk);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_dma_gnt", 32'(dma_gnt), 32'd0);
        chk("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
        chk("rst_done", 32'(dma_done), 32'd0);
        chk("rst_mem_wr", 32'(mem_wr), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        Rst = 1'b0;
        dma_req = 1'b0;
        tick();
        @(negedge Clk);
        chk("rst_no_rvalid", 32'(dma_rvalid), 32'd0);
        tick();
        ended = 1'b1;
        break;
      end
      tick();
    end
    if (!ended) begin
      if (cpu_at >= 0) begin
        // Waiting CPU wins the arbitration at the last beat.
        cpu_req = 1'b0; dma_req = 1'b0;
        @(negedge Clk);
        chk("cpu_after_burst", 32'(cpu_gnt), 32'd1);
        chk("cpu_after_burst_dma", 32'(dma_gnt), 32'd0);
        chk("cpu_after_burst_addr", 32'(mem_addr), 32'h12);
        chk("cpu_after_burst_wdata", 32'(mem_wdata), 32'h7777);
        tick();
      end else begin
        // dma_req still high at the last beat restarted a burst; dropping it aborts that.
        dma_req = 1'b0;
        @(negedge Clk);
        chk("post_burst_gnt", 32'(dma_gnt), 32'd0);
        chk("post_burst_mem_wr", 32'(mem_wr), 32'd0);
        tick();
      end
      @(negedge Clk);
      chk("post_burst_owner", 32'(owner), 32'd0);
      tick();
    end
    $display("dma %s base=%02h len=%0d abort=%0d rst=%0d cpu=%0d", wr ? "wr" : "rd",
             base, len, abort_at, rst_at, cpu_at);
  endtask

  initial begin
    vecs[0] = '{1'b1, 8'h12, 16'hABCD, 16'h0000};
    vecs[1] = '{1'b0, 8'h12, 16'h0000, 16'hABCD};
    vecs[2] = '{1'b1, 8'h00, 16'h0001, 16'h0000};
    vecs[3] = '{1'b1, 8'hFF, 16'hFFFF, 16'h0000};
    vecs[4] = '{1'b0, 8'h00, 16'h0000, 16'h0001};
    vecs[5] = '{1'b0, 8'hFF, 16'h0000, 16'hFFFF};
    vecs[6] = '{1'b1, 8'h12, 16'h5A5A, 16'h0000};
    vecs[7] = '{1'b0, 8'h12, 16'h0000, 16'h5A5A};
    vecs[8] = '{1'b1, 8'h80, 16'h1234, 16'h0000};
    vecs[9] = '{1'b0, 8'h80, 16'h0000, 16'h1234};

    // Reset state.
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("reset_owner", 32'(owner), 32'd0);
    chk("reset_cpu_gnt", 32'(cpu_gnt), 32'd0);
    chk("reset_dma_gnt", 32'(dma_gnt), 32'd0);
    chk("reset_dma_done", 32'(dma_done), 32'd0);
    chk("reset_mem_wr", 32'(mem_wr), 32'd0);
    chk("reset_mem_addr", 32'(mem_addr), 32'd0);
    chk("reset_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("reset_rvalid", 32'({cpu_rvalid, dma_rvalid}), 32'd0);
    tick();
    Rst = 1'b0;
    tick();

    // Table of single CPU accesses.
    for (int v = 0; v < 10; v++)
      cpu_op(vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].exp_rdata);

    // Bursts: wrapping write, read-back, aborted read.
    dma_burst(1'b1, 8'hFE, 4'd3, -1, -1, -1);
    dma_burst(1'b0, 8'hFE, 4'd3, -1, -1, -1);
    dma_burst(1'b0, 8'hFE, 4'd5, 2, -1, -1);

    // Both masters requesting every cycle. CPU last held no pending
    // priority handoff here (previous completed grant was a DMA burst).
    begin
      logic exp_cpu;
      cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 8'h30; cpu_wdata = 16'h3333;
      dma_req = 1'b1; dma_wr = 1'b1; dma_addr = 8'h50; dma_len = 4'd1; dma_wdata = 16'h5555;
      model[8'h30] = 16'h3333;
      if (RR) begin model[8'h50] = 16'h5555; model[8'h51] = 16'h5555; end
      @(negedge Clk);
      chk("both_first_cycle", 32'({cpu_gnt, dma_gnt}), 32'd0);
      tick();
      for (int c = 1; c <= 12; c++) begin
        exp_cpu = RR ? ((c - 1) % 3 == 0) : 1'b1;
        @(negedge Clk);
        chk("both_cpu_gnt", 32'(cpu_gnt), 32'(exp_cpu));
        chk("both_dma_gnt", 32'(dma_gnt), 32'(!exp_cpu));
        tick();
      end
      cpu_req = 1'b0; dma_req = 1'b0;
      tick();
      @(negedge Clk);
      chk("both_end_owner", 32'(owner), 32'd0);
      tick();
      $display("both-request run: %s priority, 12 cycles", RR ? "round-robin" : "fixed CPU");
    end

    // CPU request arriving mid-burst, then reset in the middle of a read burst.
    dma_burst(1'b1, 8'h40, 4'd7, -1, -1, 1);
    dma_burst(1'b0, 8'h40, 4'd7, -1, 4, -1);

    // Arbiter works normally after the mid-burst reset.
    cpu_op(1'b0, 8'h12, 16'h0000, 16'h7777);

    repeat (3) tick();
    chk("cpu_q_drained", 32'(cpu_q.size()), 32'd0);
    chk("dma_q_drained", 32'(dma_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
